// File: rtl/grid_pkg.sv
// Shared grid constants and scanner FSM state encoding.
package grid_pkg;

  localparam int unsigned GRID_COLS    = 16;
  localparam int unsigned GRID_ROWS    = 16;
  localparam int unsigned GRID_CELL_W  = 10;
  localparam int unsigned GRID_SPACING = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/grid_axis_counter.sv
// One grid axis: cell index plus top-left pixel accumulator, wrapping after N cells.
module grid_axis_counter #(
  parameter int unsigned N    = 16,
  parameter int unsigned STEP = 12,
  parameter int unsigned IW   = 4,
  parameter int unsigned PW   = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [IW-1:0] idx_o,
  output logic [PW-1:0] pix_o,
  output logic          wrap_c_o
);

  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] pix_q, pix_d;

  assign wrap_c_o = (idx_q == IW'(N - 1));

  // Pixel position tracks the index by repeated addition of the cell pitch.
  always_comb begin
    idx_d = idx_q;
    pix_d = pix_q;
    if (clr_i) begin
      idx_d = '0;
      pix_d = '0;
    end else if (inc_i) begin
      if (wrap_c_o) begin
        idx_d = '0;
        pix_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
        pix_d = pix_q + PW'(STEP);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      pix_q <= '0;
    end else begin
      idx_q <= idx_d;
      pix_q <= pix_d;
    end
  end

  assign idx_o = idx_q;
  assign pix_o = pix_q;

endmodule

// File: rtl/grid_scanner.sv
// Row-major grid cell scanner with ack handshake; GRID_SCANNER_CONTINUOUS_EN
// makes the scan wrap to cell 0 instead of finishing after one pass.
module grid_scanner
  import grid_pkg::*;
#(
  parameter int unsigned COLS    = GRID_COLS,
  parameter int unsigned ROWS    = GRID_ROWS,
  parameter int unsigned CELL_W  = GRID_CELL_W,
  parameter int unsigned SPACING = GRID_SPACING,
  localparam int unsigned ADDR_W = $clog2(COLS * ROWS),
  localparam int unsigned X_W    = $clog2(COLS),
  localparam int unsigned Y_W    = $clog2(ROWS),
  localparam int unsigned PX_W   = 10,
  localparam int unsigned PY_W   = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              ack,
  output logic              valid,
  output logic [ADDR_W-1:0] address,
  output logic [X_W-1:0]    cell_x,
  output logic [Y_W-1:0]    cell_y,
  output logic [PX_W-1:0]   pixel_x,
  output logic [PY_W-1:0]   pixel_y,
  output logic              busy,
  output logic              scan_done
);

  localparam int unsigned PITCH = CELL_W + SPACING;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              adv_c, clr_c;
  logic              x_wrap_c, y_wrap_c;

  grid_axis_counter #(
    .N(COLS), .STEP(PITCH), .IW(X_W), .PW(PX_W)
  ) u_x_axis (
    .clk_i(clock), .rst_ni(reset), .clr_i(clr_c), .inc_i(adv_c),
    .idx_o(cell_x), .pix_o(pixel_x), .wrap_c_o(x_wrap_c)
  );

  grid_axis_counter #(
    .N(ROWS), .STEP(PITCH), .IW(Y_W), .PW(PY_W)
  ) u_y_axis (
    .clk_i(clock), .rst_ni(reset), .clr_i(clr_c), .inc_i(adv_c & x_wrap_c),
    .idx_o(cell_y), .pix_o(pixel_y), .wrap_c_o(y_wrap_c)
  );

  // Abort outranks ack and start; ack only counts while a cell is presented.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    adv_c   = 1'b0;
    clr_c   = 1'b0;
    done_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (abort) begin
          state_d = ST_IDLE;
          clr_c   = 1'b1;
        end else if (ack) begin
          adv_c = 1'b1;
          if (x_wrap_c && y_wrap_c) begin
            done_d = 1'b1;
            clr_c  = 1'b1;
`ifdef GRID_SCANNER_CONTINUOUS_EN
            state_d = ST_SCAN;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        clr_c   = 1'b1;
      end
    endcase
    if (clr_c) addr_d = '0;
    else if (adv_c) addr_d = addr_q + ADDR_W'(1);
    valid_d = (state_d == ST_SCAN);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
    end
  end

  assign valid     = valid_q;
  assign busy      = busy_q;
  assign scan_done = done_q;
  assign address   = addr_q;

endmodule

// File: tb/tb_grid_scanner.sv
// Bench for grid_scanner: default 16x16 grid and a 5x3 grid driven in lockstep.
module tb_grid_scanner;

`ifdef GRID_SCANNER_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, start, abort, ack;

  logic       d0_valid, d0_busy, d0_done;
  logic [7:0] d0_address;
  logic [3:0] d0_cx, d0_cy;
  logic [9:0] d0_px;
  logic [8:0] d0_py;

  logic       d1_valid, d1_busy, d1_done;
  logic [3:0] d1_address;
  logic [2:0] d1_cx;
  logic [1:0] d1_cy;
  logic [9:0] d1_px;
  logic [8:0] d1_py;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  grid_scanner u_dut0 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .ack(ack),
    .valid(d0_valid), .address(d0_address), .cell_x(d0_cx), .cell_y(d0_cy),
    .pixel_x(d0_px), .pixel_y(d0_py), .busy(d0_busy), .scan_done(d0_done)
  );

  grid_scanner #(.COLS(5), .ROWS(3), .CELL_W(4), .SPACING(1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .ack(ack),
    .valid(d1_valid), .address(d1_address), .cell_x(d1_cx), .cell_y(d1_cy),
    .pixel_x(d1_px), .pixel_y(d1_py), .busy(d1_busy), .scan_done(d1_done)
  );

  // Reference model: mode 0=idle 1=scanning 2=finished, idx = current linear cell.
  int m_mode[2];
  int m_idx[2];
  int m_done[2];
  int m_cols[2] = '{16, 5};
  int m_rows[2] = '{16, 3};
  int m_step[2] = '{12, 5};

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0;
      m_idx[d]  = 0;
      m_done[d] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit a, input bit k);
    for (int d = 0; d < 2; d++) begin
      m_done[d] = 0;
      case (m_mode[d])
        0: if (s && !a) begin
          m_mode[d] = 1;
          m_idx[d]  = 0;
        end
        1: if (a) begin
          m_mode[d] = 0;
          m_idx[d]  = 0;
        end else if (k) begin
          if (m_idx[d] == m_cols[d] * m_rows[d] - 1) begin
            m_done[d] = 1;
            m_idx[d]  = 0;
            if (!CONT) m_mode[d] = 2;
          end else begin
            m_idx[d] = m_idx[d] + 1;
          end
        end
        default: m_mode[d] = 0;
      endcase
    end
  endtask

  task automatic chk_dut(input int d, input int v, input int b, input int sd, input int ad,
                         input int cx, input int cy, input int px, input int py);
    string p;
    int ecx, ecy;
    p   = (d == 0) ? "d0" : "d1";
    ecx = m_idx[d] % m_cols[d];
    ecy = m_idx[d] / m_cols[d];
    chk({p, ".valid"},     v,  (m_mode[d] == 1) ? 1 : 0);
    chk({p, ".busy"},      b,  (m_mode[d] != 0) ? 1 : 0);
    chk({p, ".scan_done"}, sd, m_done[d]);
    chk({p, ".address"},   ad, m_idx[d]);
    chk({p, ".cell_x"},    cx, ecx);
    chk({p, ".cell_y"},    cy, ecy);
    chk({p, ".pixel_x"},   px, ecx * m_step[d]);
    chk({p, ".pixel_y"},   py, ecy * m_step[d]);
  endtask

  task automatic chk_model();
    chk_dut(0, int'(d0_valid), int'(d0_busy), int'(d0_done), int'(d0_address),
            int'(d0_cx), int'(d0_cy), int'(d0_px), int'(d0_py));
    chk_dut(1, int'(d1_valid), int'(d1_busy), int'(d1_done), int'(d1_address),
            int'(d1_cx), int'(d1_cy), int'(d1_px), int'(d1_py));
  endtask

  task automatic step(input bit s, input bit a, input bit k);
    start = s;
    abort = a;
    ack   = k;
    @(posedge clock);
    model_step(s, a, k);
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    start = 1'b0;
    abort = 1'b0;
    ack   = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    chk_model();
    @(posedge clock);
    #1;
    reset = 1'b1;
    #2;
  endtask

  typedef struct {
    bit s;
    bit a;
    bit k;
    int addr;
    int v;
    int px;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 0, 1, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1, 1, 12};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2, 1, 24};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 3, 1, 36};
    for (int i = 5; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 3, 1, 36};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 3, 1, 36};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 4, 1, 48};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 0, 0, 0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 0, 1, 0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 0, 0, 0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].s, tbl[i].a, tbl[i].k);
      chk($sformatf("tbl%0d.address", i), int'(d0_address), tbl[i].addr);
      chk($sformatf("tbl%0d.valid", i),   int'(d0_valid),   tbl[i].v);
      chk($sformatf("tbl%0d.pixel_x", i), int'(d0_px),      tbl[i].px);
      chk($sformatf("tbl%0d.scan_done", i), int'(d0_done),  0);
    end

    // Full pass with ack held high.
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      chk("full.address", int'(d0_address), i);
      chk("full.valid", int'(d0_valid), 1);
      if (i == 17) begin
        chk("cell17.x", int'(d0_cx), 1);
        chk("cell17.y", int'(d0_cy), 1);
        chk("cell17.px", int'(d0_px), 12);
        chk("cell17.py", int'(d0_py), 12);
      end
      if (i == 14) begin
        chk("small.last.addr", int'(d1_address), 14);
        chk("small.last.x", int'(d1_cx), 4);
        chk("small.last.y", int'(d1_cy), 2);
        chk("small.last.px", int'(d1_px), 20);
        chk("small.last.py", int'(d1_py), 10);
      end
      step(1'b0, 1'b0, 1'b1);
    end
    chk("full.scan_done", int'(d0_done), 1);
    chk("full.end_valid", int'(d0_valid), CONT ? 1 : 0);
    chk("full.end_addr", int'(d0_address), 0);
    step(1'b1, 1'b0, 1'b1);
    chk("full.done_once", int'(d0_done), 0);
    chk("full.start_in_done", int'(d0_busy), CONT ? 1 : 0);

    // Abort at address 40, then restart.
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1);
    chk("abort.pre_addr", int'(d0_address), 40);
    step(1'b1, 1'b1, 1'b1);
    chk("abort.valid", int'(d0_valid), 0);
    chk("abort.addr", int'(d0_address), 0);
    chk("abort.done", int'(d0_done), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("restart.valid", int'(d0_valid), 1);
    chk("restart.addr", int'(d0_address), 0);

    // Asynchronous reset in the middle of a scan.
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1);
    chk("rst.pre_addr", int'(d0_address), 100);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst.async_addr", int'(d0_address), 0);
    chk("rst.async_valid", int'(d0_valid), 0);
    chk_model();
    @(posedge clock);
    #1;
    chk_model();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    chk("rst.idle_busy", int'(d0_busy), 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 8) == 0, ($urandom % 64) == 0, ($urandom % 4) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
